vid_ctrl_regs: RTL
==================

Name: vid_ctrl_regs

Overview:
- Parametrised APB register bank and frame-synchronous shadow controller for a multi-channel video pipeline (VI/VP/VO style channels).
- Software writes per-channel pending registers. Pending values are committed to the active outputs on the channel's next vsync rising edge, or immediately on request.
- Provides per-channel frame counters, W1C interrupt status with enables, and an error response on unmapped or read-only accesses.
- Sits between the SoC APB bridge and the video datapath control inputs.

Parameters:
- NUM_CH, 2, number of video channels (1..10).
- ADDR_W, 6, APB word-address width; requires 4+4*NUM_CH <= 2**ADDR_W.
- FCNT_W, 16, frame counter width (1..31).
- WDOG_W, 24, watchdog counter width; used only with the optional feature.

Ports:
- io_ahb_PCLK  in  1  bus and register clock.
- io_ahb_PRESET  in  1  asynchronous, active-high reset.
- io_ahb_PADDR  in  ADDR_W  word address.
- io_ahb_PSEL  in  1  select.
- io_ahb_PENABLE  in  1  access phase.
- io_ahb_PWRITE  in  1  1 = write.
- io_ahb_PWDATA  in  32  write data.
- io_ahb_PRDATA  out  32  registered read data.
- io_ahb_PREADY  out  1  tied 1.
- io_ahb_PSLVERROR  out  1  error on unmapped or RO access.
- vid_vs  in  NUM_CH  per-channel vsync, asynchronous to PCLK.
- ch_cr  out  32*NUM_CH  active control words; channel c occupies [32c+31:32c].
- ch_start  out  32*NUM_CH  active window start, {y[31:16], x[15:0]}.
- ch_end  out  32*NUM_CH  active window end.
- irq  out  1  registered interrupt.

Behaviour:
- Map (word addresses):
  - 0 = ID, RO: {8'hD5, 8'h02, 8'(NUM_CH), 8'h00}.
  - 1 = IRQ_EN, RW.
  - 2 = IRQ_STAT, W1C.
  - 3 = reserved.
  - 4+4c = CR_c, RW pending.
  - 5+4c = START_c, RW pending.
  - 6+4c = END_c, RW pending.
  - 7+4c = STAT_c, RO: bit31 = pending flag, [FCNT_W-1:0] = frame count.
- All other addresses are unmapped.
- Reads of RW registers return the pending copy.
- APB timing: 2-cycle transfers with no wait states.
  - PRDATA is loaded on the setup cycle (PSEL & ~PENABLE & ~PWRITE) and held otherwise.
  - A write takes effect at the access-phase edge (PSEL & PENABLE & PWRITE).
  - PSLVERROR = PSEL & PENABLE & (unmapped | (PWRITE & RO address)). Errored writes change nothing; errored reads leave PRDATA at 0.
- Pending flag: any write to CR_c/START_c/END_c sets pend_c.
  - If pend_c is already set, the write also sets IRQ_STAT overrun bit [NUM_CH+c].
- vsync path: vid_vs[c] passes through a 2-flop synchroniser plus an edge flop.
  - A rising edge fires 3 PCLK edges after the first edge that samples vid_vs high.
  - Each edge increments FCNT_c, wrapping from all-ones to 0.
- Commit: on a vsync edge with pend_c=1, active regs <= pending regs, pend_c clears, and IRQ_STAT[c] sets.
  - A vsync edge with pend_c=0 only increments the counter.
- Immediate commit: a CR_c write with PWDATA[31]=1 commits on the following cycle without waiting for vsync and sets IRQ_STAT[c]. Bit 31 is stored as 0.
- Simultaneous write and vsync edge on the same channel:
  - The commit uses the pre-write pending values.
  - pend_c remains set, so the new value commits at the next frame.
  - No overrun is flagged.
- IRQ_STAT W1C in the same cycle as a hardware set: set wins.
- irq <= |(IRQ_STAT & IRQ_EN), one cycle after the status change.
- Reset values: all registers, active outputs, PRDATA, irq, synchroniser and counters are 0.
- vid_vs held high through reset release produces one edge about 3 cycles after release. This is permitted.
- Reset mid-transfer aborts the transfer with no register effect.

Optional Feature:
- Macro VID_CTRL_WDOG_EN.
- Defined: each channel has a WDOG_W counter.
  - The counter is cleared by a vsync edge or when CR_c bit0 (active) = 0.
  - It otherwise increments while active CR_c bit0 = 1.
  - On reaching all-ones it sets IRQ_STAT[2*NUM_CH+c], stays saturated, and holds until the next vsync.
- Undefined: no counters are built and IRQ_STAT[2*NUM_CH+c] always reads 0.

Decomposition:
- Package vid_ctrl_pkg holds:
  - register offsets: ID/IRQ_EN/IRQ_STAT, channel base 4, stride 4;
  - field offsets: CR/START/END/STAT;
  - the ID constant;
  - the IMM bit index (31) and pending-flag bit index (31).
- Sub-module vid_ctrl_vs_sync, one instance per channel, contains the synchroniser, edge detect, frame counter and optional watchdog.

Test Plan:
- After reset, read addr 0 with NUM_CH=2 -> PRDATA=32'hD5020200. Read addr 3 -> PSLVERROR=1 and PRDATA=0.
- Write START_0=32'h0010_0020 -> ch_start[31:0] stays 0 and STAT_0 bit31=1. Pulse vid_vs[0] -> after 3 cycles ch_start[31:0]=32'h00100020, pend clears, IRQ_STAT[0]=1. With IRQ_EN=1, irq=1 one cycle later.
- Write CR_1 twice before vsync -> IRQ_STAT[3]=1. Write IRQ_STAT=32'h8 -> bit3 clears and irq drops one cycle later.
- Write CR_0=32'h8000_0005 -> ch_cr[31:0]=32'h00000005 on the next cycle without vsync, and IRQ_STAT[0]=1.
- Align a CR_0 write with the vsync edge cycle -> the old pending value commits, pend stays 1, and the new value commits at the following vsync.
- Apply 2^16 vsync pulses with FCNT_W=16 -> STAT_0 count wraps to 0. With VID_CTRL_WDOG_EN, WDOG_W=8 and CR bit0=1, 255 cycles without vsync -> IRQ_STAT[4]=1.

Source files
------------

// File: rtl/vid_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vid_ctrl_pkg
// Shared constants for the video control register bank: register word
// offsets, per-channel field layout, the ID word and the control bit indices.
// Imported by vid_ctrl_regs and vid_ctrl_vs_sync.
// ---------------------------------------------------------------------------
package vid_ctrl_pkg;

    // Global register word addresses
    localparam int REG_ID       = 0;
    localparam int REG_IRQ_EN   = 1;
    localparam int REG_IRQ_STAT = 2;

    // Per-channel block: base word address and stride between channels
    localparam int CH_BASE   = 4;
    localparam int CH_STRIDE = 4;

    // Field offset inside a channel block
    typedef enum logic [1:0] {
        FLD_CR    = 2'd0,
        FLD_START = 2'd1,
        FLD_END   = 2'd2,
        FLD_STAT  = 2'd3
    } chField_e;

    // ID register fields
    localparam logic [7:0] ID_MAGIC   = 8'hD5;
    localparam logic [7:0] ID_VERSION = 8'h02;

    // CR write bit requesting an immediate commit, and STAT pending flag bit
    localparam int IMM_BIT  = 31;
    localparam int PEND_BIT = 31;

    function automatic logic [31:0] idWord(input int numCh);
        return {ID_MAGIC, ID_VERSION, 8'(numCh), 8'h00};
    endfunction

endpackage

// File: rtl/vid_ctrl_vs_sync.sv
// ---------------------------------------------------------------------------
// vid_ctrl_vs_sync
// Per-channel vsync handling: 2-flop synchroniser, rising-edge detect and a
// wrapping frame counter. With VID_CTRL_WDOG_EN defined it also carries a
// saturating watchdog that flags a missing vsync while the channel is active.
//
// Ports:
//   clock_i    register clock
//   reset_i    asynchronous active-high reset
//   vs_i       raw vsync, asynchronous to clock_i
//   active_i   active CR bit0 of this channel (watchdog enable)
//   edge_o     one-cycle pulse on a synchronised vsync rising edge
//   fcnt_o     frame count
//   wdogHit_o  one-cycle pulse when the watchdog reaches all-ones
// ---------------------------------------------------------------------------
module vid_ctrl_vs_sync #(
    parameter int FCNT_W = 16,
    parameter int WDOG_W = 24
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              vs_i,
    input  logic              active_i,
    output logic              edge_o,
    output logic [FCNT_W-1:0] fcnt_o,
    output logic              wdogHit_o
);

    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    logic [1:0]        sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // Edge is formed from the second synchroniser stage and the edge flop,
    // so its effect lands on the third clock edge after vs_i is first seen.
    always_comb begin
        sync_d = {sync_q[0], vs_i};
        prev_d = sync_q[1];
        edge_o = sync_q[1] & ~prev_q;
        fcnt_d = edge_o ? fcnt_q + FCNT_ONE : fcnt_q;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign fcnt_o = fcnt_q;

`ifdef VID_CTRL_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
    localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Counts frames-worth of cycles while active; sticks at all-ones until
    // the next vsync edge (or deactivation) clears it.
    always_comb begin
        wdog_d = wdog_q;
        if (edge_o || !active_i) begin
            wdog_d = '0;
        end else if (wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + WDOG_ONE;
        end
    end

    assign wdogHit_o = active_i & ~edge_o & (wdog_q == WDOG_MAX - WDOG_ONE);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unusedWdog;
    assign unusedWdog = active_i ^ (WDOG_W > 0);
    assign wdogHit_o  = 1'b0;
`endif

endmodule

// File: rtl/vid_ctrl_regs.sv
// ---------------------------------------------------------------------------
// vid_ctrl_regs
// APB register bank with frame-synchronous shadow registers for NUM_CH video
// channels. Software writes pending CR/START/END copies; they move to the
// active outputs on the channel's next vsync edge, or on the cycle after a CR
// write with bit31 set. Also provides frame counters, W1C interrupt status
// with enables, and PSLVERROR on unmapped or read-only accesses.
// Optional watchdog per channel: define VID_CTRL_WDOG_EN.
//
// Ports:
//   io_ahb_PCLK / io_ahb_PRESET   clock, asynchronous active-high reset
//   io_ahb_P*                     APB slave (word addressed, no wait states)
//   vid_vs                        per-channel vsync, asynchronous
//   ch_cr / ch_start / ch_end     active words, channel c at [32c+31:32c]
//   irq                           registered |(IRQ_STAT & IRQ_EN)
// ---------------------------------------------------------------------------
module vid_ctrl_regs
    import vid_ctrl_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 6,
    parameter int FCNT_W = 16,
    parameter int WDOG_W = 24
) (
    input  logic                  io_ahb_PCLK,
    input  logic                  io_ahb_PRESET,
    input  logic [ADDR_W-1:0]     io_ahb_PADDR,
    input  logic                  io_ahb_PSEL,
    input  logic                  io_ahb_PENABLE,
    input  logic                  io_ahb_PWRITE,
    input  logic [31:0]           io_ahb_PWDATA,
    output logic [31:0]           io_ahb_PRDATA,
    output logic                  io_ahb_PREADY,
    output logic                  io_ahb_PSLVERROR,
    input  logic [NUM_CH-1:0]     vid_vs,
    output logic [32*NUM_CH-1:0]  ch_cr,
    output logic [32*NUM_CH-1:0]  ch_start,
    output logic [32*NUM_CH-1:0]  ch_end,
    output logic                  irq
);

    localparam logic [31:0] STAT_MASK = 32'((64'd1 << (3 * NUM_CH)) - 64'd1);

    logic [31:0]       crPend_q[NUM_CH], startPend_q[NUM_CH], endPend_q[NUM_CH];
    logic [31:0]       crPend_d[NUM_CH], startPend_d[NUM_CH], endPend_d[NUM_CH];
    logic [31:0]       crAct_q[NUM_CH], startAct_q[NUM_CH], endAct_q[NUM_CH];
    logic [31:0]       crAct_d[NUM_CH], startAct_d[NUM_CH], endAct_d[NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d, imm_q, imm_d;
    logic [31:0]       irqEn_q, irqEn_d, irqStat_q, irqStat_d, prdata_q, prdata_d;
    logic              irq_q, irq_d;

    logic [NUM_CH-1:0] vsEdge, wdogHit;
    logic [FCNT_W-1:0] fcnt[NUM_CH];

    logic [31:0]       addrWide;
    logic [ADDR_W-1:0] chOff;
    logic [ADDR_W-3:0] chSel;
    chField_e          fld;
    logic              isId, isEn, isStat, isCh, isUnmapped, isRo;
    logic              wrOk, setupRd;
    logic [NUM_CH-1:0] chHit;
    logic [31:0]       rdData, statSet, w1cMask, statWord;

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        vid_ctrl_vs_sync #(
            .FCNT_W (FCNT_W),
            .WDOG_W (WDOG_W)
        ) uVsSync (
            .clock_i   (io_ahb_PCLK),
            .reset_i   (io_ahb_PRESET),
            .vs_i      (vid_vs[c]),
            .active_i  (crAct_q[c][0]),
            .edge_o    (vsEdge[c]),
            .fcnt_o    (fcnt[c]),
            .wdogHit_o (wdogHit[c])
        );
        assign ch_cr[32*c +: 32]    = crAct_q[c];
        assign ch_start[32*c +: 32] = startAct_q[c];
        assign ch_end[32*c +: 32]   = endAct_q[c];
    end

    // Address decode. The channel window is checked in 32-bit arithmetic so
    // a map that exactly fills the address space does not wrap.
    always_comb begin
        addrWide   = 32'(io_ahb_PADDR);
        chOff      = io_ahb_PADDR - ADDR_W'(CH_BASE);
        chSel      = chOff[ADDR_W-1:2];
        fld        = chField_e'(chOff[1:0]);
        isId       = (addrWide == 32'(REG_ID));
        isEn       = (addrWide == 32'(REG_IRQ_EN));
        isStat     = (addrWide == 32'(REG_IRQ_STAT));
        isCh       = (addrWide >= 32'(CH_BASE)) &&
                     (addrWide <  32'(CH_BASE + CH_STRIDE * NUM_CH));
        chHit      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chHit[c] = isCh && (chSel == (ADDR_W-2)'(c));
        end
        isUnmapped = ~(isId | isEn | isStat | isCh);
        isRo       = isId | (isCh && (fld == FLD_STAT));
        io_ahb_PSLVERROR = io_ahb_PSEL & io_ahb_PENABLE &
                           (isUnmapped | (io_ahb_PWRITE & isRo));
        wrOk       = io_ahb_PSEL & io_ahb_PENABLE & io_ahb_PWRITE & ~isUnmapped & ~isRo;
        setupRd    = io_ahb_PSEL & ~io_ahb_PENABLE & ~io_ahb_PWRITE;
    end

    // Read mux: RW channel registers return the pending copy; unmapped
    // addresses return 0 so an errored read leaves PRDATA cleared.
    always_comb begin
        rdData   = '0;
        statWord = '0;
        if (isId)   rdData = idWord(NUM_CH);
        if (isEn)   rdData = irqEn_q;
        if (isStat) rdData = irqStat_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (chHit[c]) begin
                statWord               = '0;
                statWord[FCNT_W-1:0]   = fcnt[c];
                statWord[PEND_BIT]     = pend_q[c];
                case (fld)
                    FLD_CR:    rdData = crPend_q[c];
                    FLD_START: rdData = startPend_q[c];
                    FLD_END:   rdData = endPend_q[c];
                    default:   rdData = statWord;
                endcase
            end
        end
    end

    // Next-state for the register bank. A commit (vsync with pending data,
    // or the cycle after an immediate CR write) copies the pre-write pending
    // values; a write landing in the same cycle re-arms pending without
    // counting as an overrun. Hardware status sets win over W1C clears.
    always_comb begin
        crPend_d    = crPend_q;
        startPend_d = startPend_q;
        endPend_d   = endPend_q;
        crAct_d     = crAct_q;
        startAct_d  = startAct_q;
        endAct_d    = endAct_q;
        pend_d      = pend_q;
        imm_d       = '0;
        irqEn_d     = irqEn_q;
        statSet     = '0;
        w1cMask     = '0;
        if (wrOk && isEn)   irqEn_d = io_ahb_PWDATA;
        if (wrOk && isStat) w1cMask = io_ahb_PWDATA;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((vsEdge[c] && pend_q[c]) || imm_q[c]) begin
                crAct_d[c]    = crPend_q[c];
                startAct_d[c] = startPend_q[c];
                endAct_d[c]   = endPend_q[c];
                pend_d[c]     = 1'b0;
                statSet[c]    = 1'b1;
            end
            if (wrOk && chHit[c]) begin
                if (pend_q[c] && !((vsEdge[c] && pend_q[c]) || imm_q[c])) begin
                    statSet[NUM_CH + c] = 1'b1;
                end
                pend_d[c] = 1'b1;
                case (fld)
                    FLD_CR: begin
                        crPend_d[c]          = io_ahb_PWDATA;
                        crPend_d[c][IMM_BIT] = 1'b0;
                        imm_d[c]             = io_ahb_PWDATA[IMM_BIT];
                    end
                    FLD_START: startPend_d[c] = io_ahb_PWDATA;
                    default:   endPend_d[c]   = io_ahb_PWDATA;
                endcase
            end
            if (wdogHit[c]) statSet[2*NUM_CH + c] = 1'b1;
        end
        irqStat_d = ((irqStat_q & ~w1cMask) | statSet) & STAT_MASK;
        prdata_d  = setupRd ? rdData : prdata_q;
        irq_d     = |(irqStat_q & irqEn_q);
    end

    // State registers
    always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
        if (io_ahb_PRESET) begin
            for (int c = 0; c < NUM_CH; c++) begin
                crPend_q[c]    <= '0;
                startPend_q[c] <= '0;
                endPend_q[c]   <= '0;
                crAct_q[c]     <= '0;
                startAct_q[c]  <= '0;
                endAct_q[c]    <= '0;
            end
            pend_q    <= '0;
            imm_q     <= '0;
            irqEn_q   <= '0;
            irqStat_q <= '0;
            prdata_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            crPend_q    <= crPend_d;
            startPend_q <= startPend_d;
            endPend_q   <= endPend_d;
            crAct_q     <= crAct_d;
            startAct_q  <= startAct_d;
            endAct_q    <= endAct_d;
            pend_q      <= pend_d;
            imm_q       <= imm_d;
            irqEn_q     <= irqEn_d;
            irqStat_q   <= irqStat_d;
            prdata_q    <= prdata_d;
            irq_q       <= irq_d;
        end
    end

    assign io_ahb_PRDATA = prdata_q;
    assign io_ahb_PREADY = 1'b1;
    assign irq           = irq_q;

endmodule
